// File: rtl/sc_edge_scheduler.sv
// rtl/sc_edge_scheduler.sv - stochastic Roberts-cross edge sequencing controller
//
// Accepts one 2x2 pixel window per handshake. Four LFSR-based SNGs turn the
// pixels into L = 2**LEN_LOG2 bit streams. The controller drains the datapath
// pipeline, counts ones on the returned stream s, and presents a scaled,
// saturated edge magnitude on a valid/ready output.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  window handshake, p00..p11 pixel window
//   r00..r11, sel        stream bits to the datapath (zero outside RUN)
//   s                    result stream from the datapath
//   out_valid/out_ready  result handshake, out_pixel edge magnitude
//   busy                 high during RUN and DRAIN
//   thresh, edge_flag    only with SC_EDGE_THRESH_EN defined
//
// Optional feature macro: SC_EDGE_THRESH_EN
module sc_edge_scheduler #(
    parameter int          WIDTH    = 8,
    parameter int          LEN_LOG2 = 8,
    parameter int          PIPE_LAT = 2,
    parameter logic [15:0] SEED0    = 16'hACE1,
    parameter logic [15:0] SEED1    = 16'h1D2B,
    parameter logic [15:0] SEED2    = 16'h7F31,
    parameter logic [15:0] SEED3    = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p00,
    input  logic [WIDTH-1:0] p01,
    input  logic [WIDTH-1:0] p10,
    input  logic [WIDTH-1:0] p11,
    output logic             r00,
    output logic             r01,
    output logic             r10,
    output logic             r11,
    output logic             sel,
    input  logic             s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pixel,
    output logic             busy
`ifdef SC_EDGE_THRESH_EN
    ,
    input  logic [WIDTH-1:0] thresh,
    output logic             edge_flag
`endif
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LEN_LOG2:0] PIX_MAX = (LEN_LOG2+1)'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [LEN_LOG2-1:0] step;
    logic [DW-1:0]       drain_cnt;
    logic [PIPE_LAT-1:0] run_dly;
    logic [PIPE_LAT:0]   dly_ext;
    logic [LEN_LOG2:0]   ones, ones_next, shifted;
    logic [WIDTH-1:0]    result;
    logic [15:0]         lfsr0, lfsr1, lfsr2, lfsr3;
    logic [WIDTH-1:0]    px00, px01, px10, px11;
    logic                running, sample_en;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign running = (state == RUN);

    // The delayed RUN flag lines up with the datapath latency, so s is
    // counted for exactly the L cycles that carry real stream results.
    assign dly_ext   = {run_dly, running};
    assign sample_en = run_dly[PIPE_LAT-1];
    assign ones_next = ones + {{LEN_LOG2{1'b0}}, sample_en & s};
    assign shifted   = ones_next >> (LEN_LOG2 - WIDTH);
    assign result    = (shifted > PIX_MAX) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];

    assign r00 = running && (px00 > lfsr0[WIDTH-1:0]);
    assign r01 = running && (px01 > lfsr1[WIDTH-1:0]);
    assign r10 = running && (px10 > lfsr2[WIDTH-1:0]);
    assign r11 = running && (px11 > lfsr3[WIDTH-1:0]);
    assign sel = running && (lfsr0[15] ^ lfsr2[15]);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (&step) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DW'(PIPE_LAT - 1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            drain_cnt <= '0;
            run_dly   <= '0;
            ones      <= '0;
            lfsr0     <= SEED0;
            lfsr1     <= SEED1;
            lfsr2     <= SEED2;
            lfsr3     <= SEED3;
            px00      <= '0;
            px01      <= '0;
            px10      <= '0;
            px11      <= '0;
            out_pixel <= '0;
`ifdef SC_EDGE_THRESH_EN
            edge_flag <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            run_dly <= dly_ext[PIPE_LAT-1:0];
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        px00      <= p00;
                        px01      <= p01;
                        px10      <= p10;
                        px11      <= p11;
                        lfsr0     <= SEED0;
                        lfsr1     <= SEED1;
                        lfsr2     <= SEED2;
                        lfsr3     <= SEED3;
                        step      <= '0;
                        ones      <= '0;
                        drain_cnt <= '0;
                    end
                end
                RUN: begin
                    lfsr0     <= lfsr_adv(lfsr0);
                    lfsr1     <= lfsr_adv(lfsr1);
                    lfsr2     <= lfsr_adv(lfsr2);
                    lfsr3     <= lfsr_adv(lfsr3);
                    step      <= step + 1'b1;
                    ones      <= ones_next;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    ones      <= ones_next;
                    // Final sample lands on the same edge that enters DONE.
                    if (state_next == DONE) begin
                        out_pixel <= result;
`ifdef SC_EDGE_THRESH_EN
                        edge_flag <= (result >= thresh);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_edge_scheduler.sv
// tb/tb_sc_edge_scheduler.sv - scoreboard bench for sc_edge_scheduler
module tb_sc_edge_scheduler;

    localparam int W = 8;
    localparam int LG = 8;
    localparam int PL = 2;
    localparam int L = 1 << LG;
    localparam int SPACING = L + PL + 2;
    localparam logic [15:0] SEEDS [4] = '{16'hACE1, 16'h1D2B, 16'h7F31, 16'hB400};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] p00 = '0, p01 = '0, p10 = '0, p11 = '0;
    logic         r00, r01, r10, r11, sel;
    logic         s;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_pixel;
    logic         busy;
`ifdef SC_EDGE_THRESH_EN
    logic [W-1:0] thresh = 8'd64;
    logic         edge_flag;
`endif

    sc_edge_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .r00(r00), .r01(r01), .r10(r10), .r11(r11), .sel(sel), .s(s),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .busy(busy)
`ifdef SC_EDGE_THRESH_EN
        , .thresh(thresh), .edge_flag(edge_flag)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Datapath stand-in: mode 0 all ones, 1 passes r00, 2 ORs r01/r10,
    // 3 is the Roberts cross |r00-r11| / |r01-r10| chosen by sel.
    function automatic logic stub_bit(input int mode, input logic a, input logic b,
                                      input logic c, input logic d, input logic sl);
        case (mode)
            1: return a;
            2: return b | c;
            3: return sl ? (a ^ d) : (b ^ c);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= x[taps[i]-1];
        return {x[14:0], fb};
    endfunction

    // Whole-window reference: L SNG steps from fresh seeds, count, scale, clamp.
    function automatic int model(input int a, input int b, input int c, input int d, input int mode);
        logic [15:0] l [4];
        int ones = 0;
        int px [4];
        logic rb [4];
        int scaled;
        px = '{a, b, c, d};
        l = SEEDS;
        for (int st = 0; st < L; st++) begin
            for (int k = 0; k < 4; k++) rb[k] = (px[k] > int'(l[k] & 16'((1 << W) - 1)));
            ones += int'(stub_bit(mode, rb[0], rb[1], rb[2], rb[3], l[0][15] ^ l[2][15]));
            for (int k = 0; k < 4; k++) l[k] = lfsr_next(l[k]);
        end
        scaled = ones >> (LG - W);
        return (scaled > (1 << W) - 1) ? (1 << W) - 1 : scaled;
    endfunction

    // Stream path delay of PL cycles through the stub.
    int next_mode = 0;
    int cur_mode = 0;
    logic cur_bit = 1'b0;
    logic [PL-1:0] pipe = '0;
    always @(negedge clk) cur_bit = stub_bit(cur_mode, r00, r01, r10, r11, sel);
    always @(posedge clk) pipe <= {pipe[PL-2:0], cur_bit};
    assign s = (cur_mode == 0) ? 1'b1 : pipe[PL-1];

    typedef struct {
        int pix;
        int acc;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int acc_cnt = 0;
    int last_acc = 0;
    bit have_last = 0;
    bit b2b = 0;

    // Stimulus side of the scoreboard: every accepted window pushes its result.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready) begin
            e.pix = model(p00, p01, p10, p11, next_mode);
            e.acc = cyc;
            q.push_back(e);
            cur_mode = next_mode;
            acc_cnt++;
            if (b2b && have_last) chk("b2b_spacing", cyc - last_acc, SPACING);
            last_acc = cyc;
            have_last = 1;
        end
    end

    // Monitor side: compares whenever the DUT presents a result.
    bit prev_valid = 0, prev_hs = 0, hs;
    logic [W-1:0] prev_pix = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            chk("streams_zero_when_idle", (!busy && (r00 | r01 | r10 | r11 | sel)), 0);
            if (prev_hs) chk("in_ready_after_take", in_ready, 1);
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else chk("valid_latency", cyc - q[0].acc, L + PL + 1);
            end
            if (out_valid && prev_valid && !prev_hs) begin
                chk("pixel_stable", out_pixel, prev_pix);
                chk("in_ready_in_done", in_ready, 0);
            end
            hs = out_valid && out_ready;
            if (hs && q.size() > 0) begin
                chk("out_pixel", out_pixel, q[0].pix);
`ifdef SC_EDGE_THRESH_EN
                chk("edge_flag", edge_flag, (q[0].pix >= 64));
`endif
                void'(q.pop_front());
            end
            prev_valid = out_valid;
            prev_hs = hs;
            prev_pix = out_pixel;
        end
    end

    bit force_hi = 0, force_lo = 0;
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = force_hi ? 1'b1 : (force_lo ? 1'b0 : ($urandom_range(0, 3) != 0));
    end

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_streams", {r00, r01, r10, r11, sel}, 0);
        chk("rst_busy", busy, 0);
`ifdef SC_EDGE_THRESH_EN
        chk("rst_edge_flag", edge_flag, 0);
`endif
    endtask

    task automatic send_window(input int a, input int b, input int c, input int d, input int mode);
        int n;
        bit ok = 0;
        @(posedge clk);
        #1;
        p00 = W'(a); p01 = W'(b); p10 = W'(c); p11 = W'(d);
        next_mode = mode;
        in_valid = 1'b1;
        n = acc_cnt;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #1;
            if (acc_cnt > n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int t = 0; t < 5000; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        bit ok;
        repeat (2) @(posedge clk);
        check_reset_state();
        @(posedge clk);
        #1 reset = 1'b0;

        // Boundary windows, then random windows and modes, random out_ready.
        send_window(0, 77, 12, 200, 1);
        send_window(255, 3, 9, 1, 1);
        send_window($urandom_range(0, 255), 5, 6, 7, 0);
        send_window(0, 0, 0, 0, 3);
        send_window(255, 0, 255, 0, 3);
        for (int i = 0; i < 5; i++)
            send_window($urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
        wait_drain();

        // Backpressure: hold out_ready low for 50 cycles in DONE.
        force_lo = 1;
        send_window($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255), 3);
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            @(posedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        repeat (50) @(posedge clk);
        force_lo = 0;
        force_hi = 1;
        wait_drain();

        // Back-to-back identical windows with in_valid held high.
        b2b = 1;
        have_last = 0;
        @(posedge clk);
        #1;
        p00 = W'($urandom_range(0, 255)); p01 = W'($urandom_range(0, 255));
        p10 = W'($urandom_range(0, 255)); p11 = W'($urandom_range(0, 255));
        next_mode = 3;
        in_valid = 1'b1;
        n = acc_cnt;
        ok = 0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #1;
            if (acc_cnt >= n + 3) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("b2b_timeout", 0, 1);
        in_valid = 1'b0;
        b2b = 0;
        wait_drain();
        force_hi = 0;

        // Reset in the middle of RUN; nothing from that window may appear.
        send_window(200, 1, 2, 3, 1);
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        check_reset_state();
        send_window(255, 0, 0, 0, 1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
